// File: rtl/fab_int_gen_if.sv
// Register/strobe bundle between firmware-facing logic and fab_int_gen.
// The master side drives the controls; the slave side returns interrupt status.
interface fab_int_gen_if #(
    parameter int PERIOD_W = 32
);
    logic                enable;
    logic [PERIOD_W-1:0] period;
    logic                period_load;
    logic                int_ack;
    logic                missed_clr;
    logic                FAB_INT_OUT;
    logic                tick;
    logic [7:0]          missed_count;
    logic [PERIOD_W-1:0] period_cur;

    modport master (
        output enable, period, period_load, int_ack, missed_clr,
        input  FAB_INT_OUT, tick, missed_count, period_cur
    );

    modport slave (
        input  enable, period, period_load, int_ack, missed_clr,
        output FAB_INT_OUT, tick, missed_count, period_cur
    );
endinterface

// File: rtl/fab_int_gen.sv
// Periodic fabric interrupt generator driving MSS FABINT.
// Level interrupt held until acked; ticks while pending are counted as misses.
module fab_int_gen #(
    parameter int PERIOD_W       = 32,
    parameter int DEFAULT_PERIOD = 1000000
) (
    input logic           clk,
    input logic           reset,
    fab_int_gen_if.slave  bus
);
    localparam logic [PERIOD_W-1:0] DEF = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TWO = PERIOD_W'(2);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                tick_q, tick_d;
    logic [7:0]          missed_q, missed_d;
    logic [PERIOD_W-1:0] load_val;
    logic                expire;
    logic                miss;

    assign load_val = (bus.period < TWO) ? TWO : bus.period;

    always_comb begin
        period_d  = period_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        missed_d  = missed_q;
        expire    = 1'b0;
        miss      = 1'b0;

        // A load restarts the phase and suppresses any expiry on this edge
        if (bus.period_load) begin
            period_d = load_val;
            cnt_d    = load_val - ONE;
        end else if (!bus.enable) begin
            cnt_d = period_q - ONE;
        end else if (cnt_q == '0) begin
            cnt_d  = period_q - ONE;
            expire = 1'b1;
        end else begin
            cnt_d = cnt_q - ONE;
        end

        tick_d = expire;

        if (expire) begin
            pending_d = 1'b1;
            miss      = pending_q & ~bus.int_ack;
        end else if (bus.int_ack) begin
            pending_d = 1'b0;
        end

        // Clear first, then count, so a same-edge miss leaves 1
        if (bus.missed_clr) begin
            missed_d = '0;
        end
        if (miss && missed_d != 8'hFF) begin
            missed_d = missed_d + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q  <= DEF;
            cnt_q     <= DEF - ONE;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            missed_q  <= '0;
        end else begin
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            missed_q  <= missed_d;
        end
    end

    assign bus.FAB_INT_OUT  = pending_q;
    assign bus.tick         = tick_q;
    assign bus.missed_count = missed_q;
    assign bus.period_cur   = period_q;
endmodule

// File: tb/tb_fab_int_gen.sv
// Self-checking bench for fab_int_gen against an edge-indexed phase model.
// Expiries are predicted from the phase start edge and period by modulo arithmetic.
module tb_fab_int_gen;
    localparam int PW  = 32;
    localparam int DEF = 10;

    logic clk = 1'b0;
    logic reset;

    fab_int_gen_if #(.PERIOD_W(PW)) bus();

    fab_int_gen #(
        .PERIOD_W      (PW),
        .DEFAULT_PERIOD(DEF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    int m_period;
    int m_phase;
    int m_missed;
    bit m_pending;
    bit m_tick;

    logic [41:0] obs;
    logic [41:0] exp_v;

    function automatic bit exp_at(int n);
        return ((n - m_phase) % m_period) == (m_period - 1);
    endfunction

    task automatic model_reset();
        m_period  = DEF;
        m_phase   = edge_n;
        m_missed  = 0;
        m_pending = 1'b0;
        m_tick    = 1'b0;
    endtask

    task automatic step();
        bit ex;
        bit inc;
        int p;
        @(posedge clk);
        ex  = 1'b0;
        inc = 1'b0;
        if (reset) begin
            model_reset();
            m_phase = edge_n + 1;
        end else begin
            if (bus.period_load) begin
                p = (bus.period < 2) ? 2 : int'(bus.period);
                m_period = p;
                m_phase  = edge_n + 1;
            end else if (!bus.enable) begin
                m_phase = edge_n + 1;
            end else begin
                ex = exp_at(edge_n);
            end
            m_tick = ex;
            if (ex) begin
                inc       = m_pending && !bus.int_ack;
                m_pending = 1'b1;
            end else if (bus.int_ack) begin
                m_pending = 1'b0;
            end
            if (bus.missed_clr) m_missed = 0;
            if (inc && m_missed < 255) m_missed++;
        end
        edge_n++;
        @(negedge clk);
        bus.period_load = 1'b0;
        bus.int_ack     = 1'b0;
        bus.missed_clr  = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.period      = '0;
        bus.period_load = 1'b0;
        bus.int_ack     = 1'b0;
        bus.missed_clr  = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            obs = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            n_chk++;
            if (obs !== {1'b0, 1'b0, 8'd0, 32'd10}) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want %h", obs, {1'b0, 1'b0, 8'd0, 32'd10});
            end
        end
        reset      = 1'b0;
        model_reset();
        bus.enable = 1'b1;
        first      = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_run: got %h want %h", obs, exp_v);
            end
            if (bus.tick && first == 0) first = k;
        end
        n_chk++;
        if (first !== 10) begin
            n_fail++;
            $display("FAIL first_tick: got cycle %0d want 10", first);
        end
    endtask

    task automatic test_ack();
        bit seen;
        step();
        bus.int_ack = 1'b1;
        step();
        n_chk++;
        if (bus.FAB_INT_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_drop: got %b want 0", bus.FAB_INT_OUT);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL ack_run: got %h want %h", obs, exp_v);
            end
            seen = bus.tick;
        end
        n_chk++;
        if (!seen || bus.FAB_INT_OUT !== 1'b1 || bus.missed_count !== 8'd0) begin
            n_fail++;
            $display("FAIL ack_rearm: got seen=%b int=%b missed=%0d want 1 1 0",
                     seen, bus.FAB_INT_OUT, bus.missed_count);
        end
    endtask

    task automatic test_missed();
        int ticks;
        int k;
        bus.int_ack    = 1'b1;
        bus.missed_clr = 1'b1;
        step();
        ticks = 0;
        k     = 0;
        while (ticks < 5 && k < 100) begin
            step();
            k++;
            if (bus.tick) ticks++;
            obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL missed_run: got %h want %h", obs, exp_v);
            end
        end
        n_chk++;
        if (ticks != 5 || bus.missed_count !== 8'd4 || bus.FAB_INT_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL missed_5: got ticks=%0d missed=%0d int=%b want 5 4 1",
                     ticks, bus.missed_count, bus.FAB_INT_OUT);
        end
        ticks = 0;
        k     = 0;
        while (ticks < 300 && k < 3500) begin
            step();
            k++;
            if (bus.tick) ticks++;
            obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL sat_run: got %h want %h", obs, exp_v);
            end
        end
        n_chk++;
        if (ticks != 300 || bus.missed_count !== 8'd255) begin
            n_fail++;
            $display("FAIL missed_sat: got ticks=%0d missed=%0d want 300 255",
                     ticks, bus.missed_count);
        end
        bus.missed_clr = 1'b1;
        step();
        n_chk++;
        if (bus.missed_count !== 8'd0) begin
            n_fail++;
            $display("FAIL missed_clr: got %0d want 0", bus.missed_count);
        end
    endtask

    task automatic test_simul();
        int prev;
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 30 && !exp_at(edge_n); k++) step();
            n_chk++;
            if (!exp_at(edge_n)) begin
                n_fail++;
                $display("FAIL simul_wait: got no expiry want expiry within 30");
            end
            prev           = int'(bus.missed_count);
            bus.int_ack    = (e == 1);
            bus.missed_clr = (e == 3);
            step();
            obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL simul_model: got %h want %h", obs, exp_v);
            end
            if (e == 1) begin
                n_chk++;
                if (bus.FAB_INT_OUT !== 1'b1 || int'(bus.missed_count) != prev) begin
                    n_fail++;
                    $display("FAIL ack_on_tick: got int=%b missed=%0d want 1 %0d",
                             bus.FAB_INT_OUT, bus.missed_count, prev);
                end
            end
            if (e == 3) begin
                n_chk++;
                if (bus.missed_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL clr_on_miss: got %0d want 1", bus.missed_count);
                end
            end
        end
    endtask

    task automatic test_period();
        for (int k = 0; k < 3; k++) step();
        bus.period      = 32'd4;
        bus.period_load = 1'b1;
        step();
        for (int k = 1; k <= 12; k++) begin
            step();
            n_chk++;
            if (bus.tick !== (k % 4 == 0) || bus.period_cur !== 32'd4) begin
                n_fail++;
                $display("FAIL period4: got tick=%b cur=%0d at k=%0d want %b 4",
                         bus.tick, bus.period_cur, k, (k % 4 == 0));
            end
        end
        bus.period      = 32'd0;
        bus.period_load = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            step();
            n_chk++;
            if (bus.tick !== (k % 2 == 0) || bus.period_cur !== 32'd2) begin
                n_fail++;
                $display("FAIL clamp: got tick=%b cur=%0d at k=%0d want %b 2",
                         bus.tick, bus.period_cur, k, (k % 2 == 0));
            end
        end
    endtask

    task automatic test_enable();
        bus.period      = 32'd10;
        bus.period_load = 1'b1;
        step();
        for (int k = 0; k < 3; k++) step();
        bus.enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            n_chk++;
            if (bus.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled_tick: got %b want 0", bus.tick);
            end
        end
        bus.enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_chk++;
            if (bus.tick !== (k == 10)) begin
                n_fail++;
                $display("FAIL reenable: got tick=%b at k=%0d want %b",
                         bus.tick, k, (k == 10));
            end
        end
    endtask

    task automatic test_async_reset();
        int first;
        bus.period      = 32'd5;
        bus.period_load = 1'b1;
        step();
        for (int k = 0; k < 12; k++) step();
        obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
        exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset: got %h want %h", obs, exp_v);
        end
        #2 reset = 1'b1;
        #1;
        obs = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
        n_chk++;
        if (obs !== {1'b0, 1'b0, 8'd0, 32'd10}) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs, {1'b0, 1'b0, 8'd0, 32'd10});
        end
        #1 reset = 1'b0;
        model_reset();
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset: got %h want %h", obs, exp_v);
            end
            if (bus.tick && first == 0) first = k;
        end
        n_chk++;
        if (first !== 10) begin
            n_fail++;
            $display("FAIL post_reset_tick: got cycle %0d want 10", first);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            bus.enable      = ($urandom_range(0, 9) != 0);
            bus.period_load = ($urandom_range(0, 24) == 0);
            bus.period      = 32'($urandom_range(0, 12));
            bus.int_ack     = ($urandom_range(0, 5) == 0);
            bus.missed_clr  = ($urandom_range(0, 30) == 0);
            step();
            obs   = {bus.FAB_INT_OUT, bus.tick, bus.missed_count, bus.period_cur};
            exp_v = {m_pending, m_tick, 8'(m_missed), 32'(m_period)};
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random: got %h want %h at edge %0d", obs, exp_v, edge_n);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ack();
        test_missed();
        test_simul();
        test_period();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
